fifo_dp_ram: RTL and testbench
==============================

Name: fifo_dp_ram

Overview:
- Parametrised simple-dual-port RAM (one write port, one read port) on a single clock. It is the storage element for the FIFO datapath.
- Generalises the earlier 8-bit memory with:
  - per-byte write enables
  - selectable read latency (1 or 2)
  - defined read-during-write behaviour
  - a hardware initialisation sweep with a busy flag, on reset and on demand.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, width of one write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1, either 1 or 2 clock edges from read request to data; any other value is an elaboration error.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (merged) data.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the init sweep.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- clear  in  1  single-cycle request to re-run the init sweep.
- init_busy  out  1  high while the init sweep is in progress.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  NUM_BYTES  byte-lane enables; bit k covers wr_data[k*BYTE_WIDTH +: BYTE_WIDTH].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle strobe; rd_data holds the requested word in this cycle.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=S_INIT, sweep counter=0, init_busy=1, rd_data=0, rd_valid=0, all read pipeline valids=0.
  - Memory array contents are not reset directly; the init sweep clears them.
- State machine, states S_INIT and S_RUN:
  - S_INIT: on each edge, write INIT_VALUE to mem[cnt] with all lanes enabled, then cnt++.
  - S_INIT -> S_RUN on the edge that writes address DEPTH-1. init_busy therefore drops exactly DEPTH edges after rstn release.
  - S_RUN -> S_INIT on an edge with clear=1; cnt restarts at 0 and init_busy=1 from the next cycle.
  - clear while in S_INIT is ignored; the sweep is not restarted.
  - rstn asserted mid-sweep aborts it; the sweep restarts from address 0 after release.
- Gating while init_busy=1:
  - wr_en and rd_en are ignored and dropped, not queued.
  - rd_valid stays 0 and rd_data holds its value.
  - Read requests already in the pipeline when clear is sampled still complete.
- Write in S_RUN: on an edge with wr_en=1, each lane k with wr_be[k]=1 is updated; other lanes keep their value. wr_be=0 is a no-op.
- Read in S_RUN:
  - READ_LATENCY=1: rd_en sampled at edge N -> rd_data updated at edge N, rd_valid=1 for the cycle after edge N.
  - READ_LATENCY=2: one extra output register; data and rd_valid appear one edge later.
  - Back-to-back reads sustain one word per cycle.
  - rd_data holds its last value when no read completes.
- Read-during-write, rd_addr==wr_addr on the same edge, both enabled:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the byte-merged post-write word (bypass path).
  - Different addresses never interact.
- Sweep counter is ADDR_WIDTH+1 bits wide; no wrap-around inside the array.

Decomposition:
- Package fifo_mem_pkg holds:
  - state enum {S_INIT, S_RUN}
  - RDW_OLD=0 and RDW_NEW=1 constants
  - a byte-merge function: old word, new word, enable vector -> merged word.
- Sub-module fifo_mem_init_seq contains the sweep counter, the state machine and init_busy. It drives the internal write mux that selects sweep writes over user writes.

Test Plan:
- Power-up, DEPTH=32, INIT_VALUE=32'hA5A5A5A5: release rstn -> init_busy high for exactly 32 edges; then reading all 32 addresses returns 32'hA5A5A5A5.
- Byte enables: write 32'h11223344 to addr 3 with be=4'hF, then 32'hAABBCCDD with be=4'b0101 -> read of addr 3 returns 32'h11BB33DD.
- Latency: READ_LATENCY=1 and =2 with reads of addr 0..7 on consecutive edges -> rd_valid high for 8 consecutive cycles starting 1 or 2 cycles after the first rd_en; data in order.
- Read-during-write: addr 5 holds 32'h0; on the same edge write 32'hDEADBEEF to addr 5 and read addr 5 -> RDW_MODE=0 returns 32'h0, RDW_MODE=1 returns 32'hDEADBEEF.
- clear plus gating: write 32'h12345678 to addr 9, pulse clear, issue wr_en/rd_en during busy -> no rd_valid and no write during busy; after 32 edges a read of addr 9 returns INIT_VALUE.
- Reset mid-sweep: assert rstn at sweep count 10 -> init_busy stays 1; after release it lasts a full 32 edges and all addresses read as INIT_VALUE.

Source files
------------

// File: rtl/fifo_dp_ram_pkg.sv
// Shared types and helpers for the FIFO datapath RAM: state encoding,
// read-during-write mode constants and the byte-lane merge used by the bypass path.
package fifo_mem_pkg;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Upper bound on word width accepted by byte_merge; callers size-cast in and out.
    localparam int unsigned MERGE_W = 256;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_W-1:0] be_w,
        input int unsigned        byte_w
    );
        logic [MERGE_W-1:0] m;
        logic [7:0]         bit_idx;
        logic [7:0]         lane_idx;
        m = old_w;
        for (int unsigned i = 0; i < MERGE_W; i++) begin
            bit_idx  = 8'(i);
            lane_idx = 8'(i / byte_w);
            if (be_w[lane_idx]) begin
                m[bit_idx] = new_w[bit_idx];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_dp_ram_if.sv
// Write/read/control bundle of the FIFO datapath RAM.
interface fifo_dp_ram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  clear;
    logic                  init_busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]  wr_be;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output clear, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  init_busy, rd_data, rd_valid
    );

    modport slave (
        input  clear, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output init_busy, rd_data, rd_valid
    );

endinterface

// File: rtl/fifo_dp_ram_init_seq.sv
// Init sweep sequencer: walks every address writing INIT_VALUE after reset or clear,
// and muxes sweep writes over user writes into the memory write port.
module fifo_mem_init_seq
    import fifo_mem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_BYTES  = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [NUM_BYTES-1:0]  wr_be_i,
    output logic                  init_busy_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [NUM_BYTES-1:0]  mem_wbe_o
);
    localparam int unsigned         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_o = 1'b0;
        mem_we_o    = wr_en_i;
        mem_waddr_o = wr_addr_i;
        mem_wdata_o = wr_data_i;
        mem_wbe_o   = wr_be_i;
        unique case (state_q)
            S_INIT: begin
                // User writes are dropped here; clear is ignored until the sweep ends.
                init_busy_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_waddr_o = cnt_q[ADDR_WIDTH-1:0];
                mem_wdata_o = INIT_VALUE;
                mem_wbe_o   = '1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (clear_i) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: rtl/fifo_dp_ram.sv
// Simple-dual-port RAM for the FIFO datapath: byte-enabled writes, 1- or 2-cycle reads,
// selectable read-during-write result, and a hardware init sweep on reset/clear.
module fifo_dp_ram
    import fifo_mem_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 5,
    parameter int unsigned           BYTE_WIDTH   = 8,
    parameter int unsigned           READ_LATENCY = 1,
    parameter int unsigned           RDW_MODE     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic          clk,
    input  logic          rstn,
    fifo_dp_ram_if.slave  bus
);
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("fifo_dp_ram: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0 || DATA_WIDTH > MERGE_W) begin : g_bad_width
        $error("fifo_dp_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH and <= MERGE_W");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_busy;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_BYTES-1:0]  mem_wbe;

    fifo_mem_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BYTES  (NUM_BYTES),
        .INIT_VALUE (INIT_VALUE)
    ) u_init_seq (
        .clk         (clk),
        .rstn        (rstn),
        .clear_i     (bus.clear),
        .wr_en_i     (bus.wr_en),
        .wr_addr_i   (bus.wr_addr),
        .wr_data_i   (bus.wr_data),
        .wr_be_i     (bus.wr_be),
        .init_busy_o (init_busy),
        .mem_we_o    (mem_we),
        .mem_waddr_o (mem_waddr),
        .mem_wdata_o (mem_wdata),
        .mem_wbe_o   (mem_wbe)
    );

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic                  rd_fire;
    logic                  rdw_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] bypass_word;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    // Bypass returns the write merged onto the current word, i.e. the post-edge contents.
    always_comb begin
        rd_fire     = bus.rd_en && !init_busy;
        rdw_hit     = (RDW_MODE == RDW_NEW) && bus.wr_en && !init_busy && (bus.wr_addr == bus.rd_addr);
        rd_word     = mem[bus.rd_addr];
        bypass_word = DATA_WIDTH'(byte_merge(MERGE_W'(rd_word), MERGE_W'(bus.wr_data),
                                             MERGE_W'(bus.wr_be), BYTE_WIDTH));
        s1_data_d   = s1_data_q;
        if (rd_fire) begin
            s1_data_d = rdw_hit ? bypass_word : rd_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            s1_data_q  <= s1_data_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q;
        logic [DATA_WIDTH-1:0] s2_data_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign bus.rd_data  = s2_data_q;
        assign bus.rd_valid = s2_valid_q;
    end else begin : g_lat1
        assign bus.rd_data  = s1_data_q;
        assign bus.rd_valid = s1_valid_q;
    end

    assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_fifo_dp_ram.sv
// Directed bench for fifo_dp_ram: dut_a is latency 1 / old-data RDW, dut_b is
// latency 2 / new-data RDW, both driven by the same stimulus.
module tb_fifo_dp_ram;
    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYTE_WIDTH(8)) bus_a ();
    fifo_dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYTE_WIDTH(8)) bus_b ();

    assign bus_a.clear   = clear;
    assign bus_a.wr_en   = wr_en;
    assign bus_a.wr_addr = wr_addr;
    assign bus_a.wr_data = wr_data;
    assign bus_a.wr_be   = wr_be;
    assign bus_a.rd_en   = rd_en;
    assign bus_a.rd_addr = rd_addr;
    assign bus_b.clear   = clear;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.wr_addr = wr_addr;
    assign bus_b.wr_data = wr_data;
    assign bus_b.wr_be   = wr_be;
    assign bus_b.rd_en   = rd_en;
    assign bus_b.rd_addr = rd_addr;

    fifo_dp_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(IV)
    ) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a)
    );

    fifo_dp_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(IV)
    ) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    // Checks busy for exactly 32 edges following the current point.
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("%s_busy_a_%0d", tag, i), 32'(bus_a.init_busy), 32'(i < 32));
            chk($sformatf("%s_busy_b_%0d", tag, i), 32'(bus_b.init_busy), 32'(i < 32));
        end
    endtask

    task automatic read_all_init(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i);
            tick();
            chk($sformatf("%s_va_%0d", tag, i), 32'(bus_a.rd_valid), 32'd1);
            chk($sformatf("%s_da_%0d", tag, i), bus_a.rd_data, IV);
            if (i > 0) begin
                chk($sformatf("%s_vb_%0d", tag, i), 32'(bus_b.rd_valid), 32'd1);
                chk($sformatf("%s_db_%0d", tag, i), bus_b.rd_data, IV);
            end
        end
        rd_en = 1'b0;
        tick();
        chk({tag, "_va_end"}, 32'(bus_a.rd_valid), 32'd0);
        chk({tag, "_vb_last"}, 32'(bus_b.rd_valid), 32'd1);
        chk({tag, "_db_last"}, bus_b.rd_data, IV);
        tick();
        chk({tag, "_vb_end"}, 32'(bus_b.rd_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy_a", 32'(bus_a.init_busy), 32'd1);
        chk("rst_busy_b", 32'(bus_b.init_busy), 32'd1);
        chk("rst_data_a", bus_a.rd_data, 32'h0);
        chk("rst_data_b", bus_b.rd_data, 32'h0);
        chk("rst_valid_a", 32'(bus_a.rd_valid), 32'd0);
        chk("rst_valid_b", 32'(bus_b.rd_valid), 32'd0);

        // Power-up sweep and readback
        rstn = 1'b1;
        sweep_check("pwr");
        read_all_init("pwr_rd");

        // Byte enables: 11223344 then AABBCCDD with be=0101 -> 11BB33DD
        write(5'd3, 32'h11223344, 4'hF);
        write(5'd3, 32'hAABBCCDD, 4'b0101);
        rd_en = 1'b1; rd_addr = 5'd3;
        tick();
        rd_en = 1'b0;
        chk("be_va", 32'(bus_a.rd_valid), 32'd1);
        chk("be_da", bus_a.rd_data, 32'h11BB33DD);
        chk("be_vb_early", 32'(bus_b.rd_valid), 32'd0);
        tick();
        chk("be_va_end", 32'(bus_a.rd_valid), 32'd0);
        chk("be_vb", 32'(bus_b.rd_valid), 32'd1);
        chk("be_db", bus_b.rd_data, 32'h11BB33DD);

        // Latency: back-to-back reads of addr 0..7
        for (int i = 0; i < 8; i++) write(5'(i), 32'h10000000 + 32'(i), 4'hF);
        for (int t = 0; t < 10; t++) begin
            rd_en = (t < 8); rd_addr = 5'(t);
            tick();
            chk($sformatf("lat_va_%0d", t), 32'(bus_a.rd_valid), 32'(t < 8));
            chk($sformatf("lat_da_%0d", t), bus_a.rd_data,
                (t < 8) ? 32'h10000000 + 32'(t) : 32'h10000007);
            chk($sformatf("lat_vb_%0d", t), 32'(bus_b.rd_valid), 32'(t >= 1 && t <= 8));
            chk($sformatf("lat_db_%0d", t), bus_b.rd_data,
                (t == 0) ? 32'h11BB33DD : (t <= 8) ? 32'h10000000 + 32'(t - 1) : 32'h10000007);
        end
        idle();

        // Read-during-write on addr 5
        write(5'd5, 32'h0, 4'hF);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 5'd5;
        tick();
        idle();
        chk("rdw_old_a", bus_a.rd_data, 32'h0);
        tick();
        chk("rdw_new_vb", 32'(bus_b.rd_valid), 32'd1);
        chk("rdw_new_b", bus_b.rd_data, 32'hDEADBEEF);

        // wr_be=0 is a no-op even through the bypass
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
        rd_en = 1'b1; rd_addr = 5'd5;
        tick();
        idle();
        chk("be0_a", bus_a.rd_data, 32'hDEADBEEF);
        tick();
        chk("be0_b", bus_b.rd_data, 32'hDEADBEEF);

        // Different addresses never interact
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 5'd5;
        tick();
        idle();
        chk("diff_a", bus_a.rd_data, 32'hDEADBEEF);
        tick();
        chk("diff_b", bus_b.rd_data, 32'hDEADBEEF);

        // clear with gating; a second clear mid-sweep is ignored
        write(5'd9, 32'h12345678, 4'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy_a", 32'(bus_a.init_busy), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D; wr_be = 4'hF;
            rd_en = 1'b1; rd_addr = 5'd9;
            clear = (i == 10);
            tick();
            chk($sformatf("clr_busy_%0d", i), 32'(bus_a.init_busy), 32'(i < 32));
            chk($sformatf("clr_gate_va_%0d", i), 32'(bus_a.rd_valid), 32'd0);
            chk($sformatf("clr_gate_vb_%0d", i), 32'(bus_b.rd_valid), 32'd0);
            chk($sformatf("clr_hold_a_%0d", i), bus_a.rd_data, 32'hDEADBEEF);
            chk($sformatf("clr_hold_b_%0d", i), bus_b.rd_data, 32'hDEADBEEF);
        end
        idle();
        rd_en = 1'b1; rd_addr = 5'd9;
        tick();
        rd_en = 1'b0;
        chk("clr_rd9_a", bus_a.rd_data, IV);
        tick();
        chk("clr_rd9_b", bus_b.rd_data, IV);

        // Reset mid-sweep at count 10
        write(5'd12, 32'h00000055, 4'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        rstn = 1'b0;
        #1;
        chk("mid_busy_a", 32'(bus_a.init_busy), 32'd1);
        chk("mid_data_a", bus_a.rd_data, 32'h0);
        chk("mid_data_b", bus_b.rd_data, 32'h0);
        chk("mid_valid_b", 32'(bus_b.rd_valid), 32'd0);
        tick();
        rstn = 1'b1;
        sweep_check("mid");
        read_all_init("mid_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
